// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) with a fixed 34-cycle latency.
// Results feed the HI/LO registers; done is their load enable.
module mult_div_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] srcA,
   input  logic [31:0] srcB,
   output logic        busy,
   output logic        done,
   output logic [31:0] hiOut,
   output logic [31:0] loOut,
   output logic        divByZero
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t      state_reg;
   logic [1:0]  op_reg;
   logic        a_neg_reg;
   logic        b_neg_reg;
   logic        b_zero_reg;
   logic [31:0] b_mag_reg;
   logic [31:0] acc_hi_reg;
   logic [31:0] acc_lo_reg;
   logic [4:0]  count_reg;

   logic        signed_in;
   logic [31:0] a_mag_in;
   logic [31:0] b_mag_in;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   // Both operations start from the same accumulator image: HI = 0, LO = |srcA|.
   always_comb begin
      signed_in = ~op[0];
      a_mag_in  = (signed_in && srcA[31]) ? (32'd0 - srcA) : srcA;
      b_mag_in  = (signed_in && srcB[31]) ? (32'd0 - srcB) : srcB;
   end

   // LO holds the multiplier (shifted out at bit 0) or the dividend/quotient (bit 31 out, quotient bit in).
   always_comb begin
      mul_sum   = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, b_mag_reg} : 33'd0);
      div_shift = {acc_hi_reg, acc_lo_reg[31]};
      div_ge    = (div_shift >= {1'b0, b_mag_reg});
      div_diff  = div_shift[31:0] - b_mag_reg;
   end

   always_comb begin
      prod_fix = {acc_hi_reg, acc_lo_reg};
      quot_fix = acc_lo_reg;
      rem_fix  = acc_hi_reg;
      if (a_neg_reg ^ b_neg_reg) begin
         prod_fix = 64'd0 - {acc_hi_reg, acc_lo_reg};
         quot_fix = 32'd0 - acc_lo_reg;
      end
      if (a_neg_reg)
         rem_fix = 32'd0 - acc_hi_reg;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg  <= IDLE;
         op_reg     <= 2'd0;
         a_neg_reg  <= 1'b0;
         b_neg_reg  <= 1'b0;
         b_zero_reg <= 1'b0;
         b_mag_reg  <= 32'd0;
         acc_hi_reg <= 32'd0;
         acc_lo_reg <= 32'd0;
         count_reg  <= 5'd0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hiOut      <= 32'd0;
         loOut      <= 32'd0;
         divByZero  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  op_reg     <= op;
                  a_neg_reg  <= signed_in & srcA[31];
                  b_neg_reg  <= signed_in & srcB[31];
                  b_zero_reg <= (srcB == 32'd0);
                  b_mag_reg  <= b_mag_in;
                  acc_hi_reg <= 32'd0;
                  acc_lo_reg <= a_mag_in;
                  count_reg  <= 5'd31;
                  busy       <= 1'b1;
                  state_reg  <= RUN;
               end
            end
            RUN: begin
               if (op_reg[1]) begin
                  acc_hi_reg <= div_ge ? div_diff : div_shift[31:0];
                  acc_lo_reg <= {acc_lo_reg[30:0], div_ge};
               end else begin
                  {acc_hi_reg, acc_lo_reg} <= {mul_sum, acc_lo_reg[31:1]};
               end
               if (count_reg == 5'd0)
                  state_reg <= FIX;
               else
                  count_reg <= count_reg - 5'd1;
            end
            FIX: begin
               // A zero divisor leaves |srcA| as remainder, so re-signing it restores srcA exactly.
               if (op_reg[1]) begin
                  hiOut     <= rem_fix;
                  loOut     <= b_zero_reg ? 32'hFFFF_FFFF : quot_fix;
                  divByZero <= b_zero_reg;
               end else begin
                  {hiOut, loOut} <= prod_fix;
                  divByZero      <= 1'b0;
               end
               busy      <= 1'b0;
               done      <= 1'b1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule
